// File: rtl/fish_pkg.sv
// Shared constants and state encoding for the fish sprite controller.
package fish_pkg;

  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 16;
  localparam logic [11:0] TRANSPARENT = 12'h0F0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSwimR  = 2'd1,
    StSwimL  = 2'd2,
    StCaught = 2'd3
  } fish_state_e;

endpackage

// File: rtl/fish_motion.sv
// Fish motion FSM: swim direction, x position, animation frame and respawn timer.
// Everything except the catch transition advances only on refresh_tick.
module fish_motion
  import fish_pkg::*;
#(
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 640,
  parameter int unsigned X_INIT        = 100,
  parameter int unsigned SPEED         = 1,
  parameter int unsigned ANIM_TICKS    = 8,
  parameter int unsigned RESPAWN_TICKS = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        refresh_tick,
  input  logic        enable,
  input  logic        caught,
  output fish_state_e state,
  output logic [9:0]  x,
  output logic        rom_sel
);

  localparam logic [9:0]  XRight    = 10'(X_MAX - SPRITE_W);
  localparam logic [9:0]  XMinVal   = 10'(X_MIN);
  localparam logic [9:0]  XInitVal  = 10'(X_INIT);
  localparam logic [9:0]  Speed10   = 10'(SPEED);
  localparam logic [10:0] Speed11   = 11'(SPEED);
  localparam logic [10:0] XLeftLim  = 11'(X_MIN + SPEED);
  localparam logic [15:0] AnimLast  = 16'(ANIM_TICKS - 1);
  localparam logic [15:0] RespLast  = 16'(RESPAWN_TICKS - 1);

  fish_state_e state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic        sel_q, sel_d;
  logic [15:0] anim_q, anim_d;
  logic [15:0] resp_q, resp_d;
  logic        anim_adv;
  logic [10:0] x_plus;

  assign x_plus = {1'b0, x_q} + Speed11;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= XInitVal;
      sel_q   <= 1'b0;
      anim_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sel_q   <= sel_d;
      anim_q  <= anim_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    sel_d    = sel_q;
    anim_d   = anim_q;
    resp_d   = resp_q;
    anim_adv = 1'b0;

    // A catch pulse beats a coincident refresh tick.
    if (caught && (state_q == StSwimR || state_q == StSwimL)) begin
      state_d = StCaught;
      resp_d  = '0;
    end else if (refresh_tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) state_d = StSwimR;
        end
        StSwimR: begin
          if (!enable) begin
            state_d = StIdle;
          end else begin
            anim_adv = 1'b1;
            if (x_plus >= {1'b0, XRight}) begin
              x_d     = XRight;
              state_d = StSwimL;
            end else begin
              x_d = x_plus[9:0];
            end
          end
        end
        StSwimL: begin
          if (!enable) begin
            state_d = StIdle;
          end else begin
            anim_adv = 1'b1;
            if ({1'b0, x_q} <= XLeftLim) begin
              x_d     = XMinVal;
              state_d = StSwimR;
            end else begin
              x_d = x_q - Speed10;
            end
          end
        end
        StCaught: begin
          if (resp_q == RespLast) begin
            state_d = StSwimR;
            x_d     = XInitVal;
            resp_d  = '0;
          end else begin
            resp_d = resp_q + 16'd1;
          end
        end
      endcase
    end

    if (anim_adv) begin
      if (anim_q == AnimLast) begin
        anim_d = '0;
        sel_d  = ~sel_q;
      end else begin
        anim_d = anim_q + 16'd1;
      end
    end
  end

  assign state   = state_q;
  assign x       = x_q;
  assign rom_sel = sel_q;

endmodule

// File: rtl/fish_sprite_ctrl.sv
// Fish sprite sequencer: ROM addressing from scan position, hit detection and
// a two-stage pipeline that aligns the hit flag with the 1-cycle ROM and keys transparency.
module fish_sprite_ctrl
  import fish_pkg::*;
#(
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 640,
  parameter int unsigned X_INIT        = 100,
  parameter int unsigned Y_POS         = 300,
  parameter int unsigned SPEED         = 1,
  parameter int unsigned ANIM_TICKS    = 8,
  parameter int unsigned RESPAWN_TICKS = 120
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        refresh_tick,
  input  logic        enable,
  input  logic        caught,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [3:0]  rom_row,
  output logic [4:0]  rom_col,
  output logic        rom_sel,
  input  logic [11:0] color_in,
  output logic        fish_on,
  output logic [11:0] rgb,
  output logic [9:0]  fish_x,
  output logic [9:0]  fish_y,
  output logic [1:0]  fish_state
);

  localparam logic [10:0] YTop = 11'(Y_POS);
  localparam logic [10:0] YEnd = 11'(Y_POS + SPRITE_H);
  localparam logic [10:0] SprW = 11'(SPRITE_W);
  localparam logic [3:0]  YLow = 4'(Y_POS);

  fish_state_e state;
  logic [9:0]  x;
  logic [10:0] px, py, x_lo, x_hi;
  logic [4:0]  dx;
  logic        hit, hit_d;
  logic        fish_on_q;
  logic [11:0] rgb_q;

  fish_motion #(
    .X_MIN         (X_MIN),
    .X_MAX         (X_MAX),
    .X_INIT        (X_INIT),
    .SPEED         (SPEED),
    .ANIM_TICKS    (ANIM_TICKS),
    .RESPAWN_TICKS (RESPAWN_TICKS)
  ) u_motion (
    .clk          (clk),
    .reset_n      (reset_n),
    .refresh_tick (refresh_tick),
    .enable       (enable),
    .caught       (caught),
    .state        (state),
    .x            (x),
    .rom_sel      (rom_sel)
  );

  // Offsets only need their low bits; the box test below guarantees they are in range.
  assign dx      = pixel_x[4:0] - x[4:0];
  assign rom_row = pixel_y[3:0] - YLow;
  assign rom_col = (state == StSwimL) ? (5'd31 - dx) : dx;

  // 11-bit compares so x+32 never wraps.
  assign px   = {1'b0, pixel_x};
  assign py   = {1'b0, pixel_y};
  assign x_lo = {1'b0, x};
  assign x_hi = x_lo + SprW;

  assign hit = video_on && (px >= x_lo) && (px < x_hi) && (py >= YTop) && (py < YEnd)
               && (state != StCaught);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d     <= 1'b0;
      fish_on_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hit_d     <= hit;
      fish_on_q <= hit_d && (color_in != TRANSPARENT);
      rgb_q     <= (hit_d && (color_in != TRANSPARENT)) ? color_in : 12'h000;
    end
  end

  assign fish_on    = fish_on_q;
  assign rgb        = rgb_q;
  assign fish_x     = x;
  assign fish_y     = 10'(Y_POS);
  assign fish_state = state;

endmodule

// File: tb/tb_fish_sprite_ctrl.sv
// Self-checking bench for fish_sprite_ctrl with a behavioural fish model and a
// synchronous ROM stand-in driven by the DUT's rom_sel/rom_row/rom_col.
module tb_fish_sprite_ctrl;

  localparam int XINIT = 100;
  localparam int YPOS  = 300;
  localparam int XR    = 608;
  localparam int ANIM  = 8;
  localparam int RESP  = 120;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        refresh_tick = 1'b0;
  logic        enable = 1'b0;
  logic        caught = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [3:0]  rom_row;
  logic [4:0]  rom_col;
  logic        rom_sel;
  logic [11:0] color_in;
  logic        fish_on;
  logic [11:0] rgb;
  logic [9:0]  fish_x;
  logic [9:0]  fish_y;
  logic [1:0]  fish_state;

  logic        force_en = 1'b0;
  logic [11:0] force_val = '0;

  int checks = 0;
  int errors = 0;

  // Model: state code, x, count of swimming ticks taken, ticks spent hidden.
  int m_st, m_x, m_swim, m_hidden;

  fish_sprite_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .refresh_tick (refresh_tick),
    .enable       (enable),
    .caught       (caught),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .rom_row      (rom_row),
    .rom_col      (rom_col),
    .rom_sel      (rom_sel),
    .color_in     (color_in),
    .fish_on      (fish_on),
    .rgb          (rgb),
    .fish_x       (fish_x),
    .fish_y       (fish_y),
    .fish_state   (fish_state)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic sel, input logic [3:0] r,
                                         input logic [4:0] c);
    return {sel, r, c, 2'b10};
  endfunction

  always @(posedge clk) color_in <= force_en ? force_val : rom_fn(rom_sel, rom_row, rom_col);

  function automatic logic exp_sel();
    return ((m_swim / ANIM) % 2) == 1;
  endfunction

  function automatic logic [12:0] exp_motion();
    return {m_st[1:0], m_x[9:0], exp_sel()};
  endfunction

  function automatic logic [12:0] exp_pix(input int px, input int py, input logic vo);
    int col, row;
    logic [11:0] c;
    logic inb;
    inb = vo && px >= m_x && px < m_x + 32 && py >= YPOS && py < YPOS + 16 && m_st != 3;
    col = (px - m_x) & 31;
    if (m_st == 2) col = 31 - col;
    row = (py - YPOS) & 15;
    c = force_en ? force_val : rom_fn(exp_sel(), row[3:0], col[4:0]);
    if (inb && c != 12'h0F0) return {1'b1, c};
    return 13'h0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_x = XINIT; m_swim = 0; m_hidden = 0;
  endtask

  task automatic model_step(input logic t, input logic c);
    if (c && (m_st == 1 || m_st == 2)) begin
      m_st = 3; m_hidden = 0;
    end else if (t) begin
      if (m_st == 0) begin
        if (enable) m_st = 1;
      end else if (m_st == 3) begin
        m_hidden++;
        if (m_hidden == RESP) begin m_st = 1; m_x = XINIT; m_hidden = 0; end
      end else if (!enable) begin
        m_st = 0;
      end else begin
        m_swim++;
        if (m_st == 1) begin
          if (m_x + 1 >= XR) begin m_x = XR; m_st = 2; end
          else m_x = m_x + 1;
        end else begin
          if (m_x <= 1) begin m_x = 0; m_st = 1; end
          else m_x = m_x - 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic t, input logic c);
    @(negedge clk);
    refresh_tick = t;
    caught = c;
    @(negedge clk);
    refresh_tick = 1'b0;
    caught = 1'b0;
    model_step(t, c);
  endtask

  task automatic drive_pix(input int px, input int py, input logic vo);
    @(negedge clk);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    video_on = vo;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++;
    if ({fish_state, fish_x, rom_sel, fish_on, rgb} !== {2'd0, 10'd100, 1'b0, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset: state=%0d x=%0d sel=%b on=%b rgb=%h, want 0/100/0/0/000",
               fish_state, fish_x, rom_sel, fish_on, rgb);
    end
    checks++;
    if (fish_y !== 10'd300) begin
      errors++; $display("FAIL reset_fish_y: got %0d want 300", fish_y);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    enable = 1'b0;
    repeat (3) cycle(1'b1, 1'b0);
    checks++;
    if ({fish_state, fish_x, rom_sel} !== {2'd0, 10'd100, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold: state=%0d x=%0d sel=%b want 0/100/0", fish_state, fish_x, rom_sel);
    end
    drive_pix(100, 300, 1'b1);
    @(negedge clk);
    checks++;
    if (fish_on !== 1'b0) begin
      errors++; $display("FAIL idle_latency1: fish_on=%b want 0 after 1 clk", fish_on);
    end
    @(negedge clk);
    checks++;
    if ({fish_on, rgb} !== {1'b1, 12'h002}) begin
      errors++; $display("FAIL idle_latency2: on=%b rgb=%h want 1/002", fish_on, rgb);
    end
  endtask

  task automatic test_pixel_bounds();
    int pxs[4] = '{131, 132, 131, 131};
    int pys[4] = '{315, 315, 316, 315};
    logic vos[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic ons[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [12:0] e;
    for (int i = 0; i < 4; i++) begin
      drive_pix(pxs[i], pys[i], vos[i]);
      e = exp_pix(pxs[i], pys[i], vos[i]);
      repeat (2) @(negedge clk);
      checks++;
      if ({fish_on, rgb} !== e || fish_on !== ons[i]) begin
        errors++;
        $display("FAIL bounds(%0d,%0d,vo=%b): on=%b rgb=%h want %b/%h", pxs[i], pys[i], vos[i],
                 fish_on, rgb, e[12], e[11:0]);
      end
    end
  endtask

  task automatic test_transparent();
    logic [11:0] vals[2] = '{12'h0F0, 12'hD74};
    logic [12:0] want[2] = '{13'h0000, {1'b1, 12'hD74}};
    for (int i = 0; i < 2; i++) begin
      force_en = 1'b1;
      force_val = vals[i];
      drive_pix(110, 305, 1'b1);
      repeat (3) @(negedge clk);
      checks++;
      if ({fish_on, rgb} !== want[i]) begin
        errors++;
        $display("FAIL transparent(%h): on=%b rgb=%h want %b/%h", vals[i], fish_on, rgb,
                 want[i][12], want[i][11:0]);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic test_swim();
    logic [12:0] e;
    logic sel_hold;
    enable = 1'b1;
    for (int i = 0; i < 509; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if ({fish_state, fish_x, rom_sel} !== exp_motion()) begin
        errors++;
        $display("FAIL swim_tick%0d: st=%0d x=%0d sel=%b want %0d/%0d/%b", i + 1, fish_state,
                 fish_x, rom_sel, m_st, m_x, exp_sel());
      end
    end
    checks++;
    if ({fish_state, fish_x} !== {2'd2, 10'd608}) begin
      errors++; $display("FAIL right_edge: st=%0d x=%0d want 2/608", fish_state, fish_x);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if ({fish_state, fish_x} !== {2'd2, 10'd607}) begin
      errors++; $display("FAIL turn_left: st=%0d x=%0d want 2/607", fish_state, fish_x);
    end
    drive_pix(607 + 3, 305, 1'b1);
    #1;
    checks++;
    if ({rom_row, rom_col} !== {4'd5, 5'd28}) begin
      errors++; $display("FAIL mirror_addr: row=%0d col=%0d want 5/28", rom_row, rom_col);
    end
    e = exp_pix(607 + 3, 305, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({fish_on, rgb} !== e) begin
      errors++; $display("FAIL mirror_pix: on=%b rgb=%h want %b/%h", fish_on, rgb, e[12], e[11:0]);
    end
    enable = 1'b0;
    cycle(1'b1, 1'b0);
    sel_hold = rom_sel;
    repeat (10) cycle(1'b1, 1'b0);
    checks++;
    if ({fish_state, fish_x, rom_sel} !== exp_motion() || rom_sel !== sel_hold) begin
      errors++;
      $display("FAIL idle_freeze: st=%0d x=%0d sel=%b want %0d/%0d/%b", fish_state, fish_x,
               rom_sel, m_st, m_x, exp_sel());
    end
  endtask

  task automatic test_caught();
    int x_before;
    logic [12:0] e;
    cycle(1'b0, 1'b1);
    checks++;
    if (fish_state !== 2'd0) begin
      errors++; $display("FAIL caught_in_idle: st=%0d want 0", fish_state);
    end
    enable = 1'b1;
    cycle(1'b1, 1'b0);
    x_before = m_x;
    cycle(1'b1, 1'b1);
    checks++;
    if ({fish_state, fish_x} !== {2'd3, 10'(x_before)}) begin
      errors++;
      $display("FAIL caught_tick: st=%0d x=%0d want 3/%0d", fish_state, fish_x, x_before);
    end
    drive_pix(x_before + 5, 305, 1'b1);
    e = exp_pix(x_before + 5, 305, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if ({fish_on, rgb} !== e || fish_on !== 1'b0) begin
      errors++; $display("FAIL caught_hidden: on=%b rgb=%h want 0/000", fish_on, rgb);
    end
    for (int i = 0; i < RESP; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if ({fish_state, fish_x, rom_sel} !== exp_motion()) begin
        errors++;
        $display("FAIL respawn_tick%0d: st=%0d x=%0d want %0d/%0d", i + 1, fish_state, fish_x,
                 m_st, m_x);
      end
    end
    checks++;
    if ({fish_state, fish_x} !== {2'd1, 10'd100}) begin
      errors++; $display("FAIL respawn: st=%0d x=%0d want 1/100", fish_state, fish_x);
    end
  endtask

  task automatic test_reset_midframe();
    drive_pix(105, 302, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (fish_on !== 1'b1) begin
      errors++; $display("FAIL midframe_pre: on=%b want 1", fish_on);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({fish_on, rgb, fish_state, fish_x} !== {1'b0, 12'h000, 2'd0, 10'd100}) begin
      errors++;
      $display("FAIL midframe_reset: on=%b rgb=%h st=%0d x=%0d want 0/000/0/100", fish_on, rgb,
               fish_state, fish_x);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [12:0] q[$];
    logic [12:0] e;
    int px, py;
    logic vo;
    enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      checks++;
      if ({fish_state, fish_x, rom_sel} !== exp_motion()) begin
        errors++;
        $display("FAIL random_motion@%0d: st=%0d x=%0d sel=%b want %0d/%0d/%b", i, fish_state,
                 fish_x, rom_sel, m_st, m_x, exp_sel());
      end
      if (i % 500 == 250) begin
        q.delete();
        for (int k = 0; k < 62; k++) begin
          @(negedge clk);
          if (q.size() == 2) begin
            e = q.pop_front();
            checks++;
            if ({fish_on, rgb} !== e) begin
              errors++;
              $display("FAIL random_pix@%0d.%0d: on=%b rgb=%h want %b/%h", i, k, fish_on, rgb,
                       e[12], e[11:0]);
            end
          end
          px = m_x - 4 + int'($urandom_range(0, 40));
          py = YPOS - 4 + int'($urandom_range(0, 24));
          vo = $urandom_range(0, 9) != 0;
          pixel_x = 10'(px);
          pixel_y = 10'(py);
          video_on = vo;
          q.push_back(exp_pix(px, py, vo));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_pixel_bounds();
    test_transparent();
    test_swim();
    test_caught();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
